// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module  : regfile_pkg
// Brief   : Shared defaults and constants for the ID-stage register file.
// Revision: 1.0
// ============================================================================
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int NREG       = 2 ** DEF_ADDR_W;
  localparam int REG_ZERO   = 0;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module  : reg_scoreboard
// Brief   : Per-register pending bits. Issue sets a bit, writeback clears it.
//           Set wins on collision. Two combinational lookup ports.
// Revision: 1.0
// ============================================================================
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] lk1_addr,
  output logic              lk1_busy,
  input  logic [ADDR_W-1:0] lk2_addr,
  output logic              lk2_busy
);

  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] C_ZERO = ADDR_W'(REG_ZERO);

  logic [NUM_REGS-1:0] r_pend;
  logic [NUM_REGS-1:0] w_set_mask;
  logic [NUM_REGS-1:0] w_clr_mask;

  // Register 0 never appears in either mask, so its bit stays 0 forever.
  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (set_en && set_addr != C_ZERO) w_set_mask = NUM_REGS'(1) << set_addr;
    if (clr_en && clr_addr != C_ZERO) w_clr_mask = NUM_REGS'(1) << clr_addr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pend <= '0;
    else     r_pend <= (r_pend & ~w_clr_mask) | w_set_mask;
  end

  assign lk1_busy = r_pend[lk1_addr];
  assign lk2_busy = r_pend[lk2_addr];

endmodule : reg_scoreboard
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
// Module  : reg_file
// Brief   : 2R/1W register file with pending scoreboard and registered debug
//           read port. Optional WB->read forwarding under REGFILE_BYPASS_EN.
// Revision: 1.0
// ============================================================================
module reg_file
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] r1_addr,
  output logic [DATA_W-1:0] r1_dout,
  output logic              r1_busy,
  input  logic [ADDR_W-1:0] r2_addr,
  output logic [DATA_W-1:0] r2_dout,
  output logic              r2_busy,
  input  logic [ADDR_W-1:0] r3_addr,
  input  logic [DATA_W-1:0] r3_din,
  input  logic              r3_we,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_addr,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_dout
);

  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] C_ZERO = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [DATA_W-1:0] r_dbg;
  logic [DATA_W-1:0] w_r1_raw;
  logic [DATA_W-1:0] w_r2_raw;
  logic              w_sb_busy1;
  logic              w_sb_busy2;
  logic              w_wb_hit;

  assign w_wb_hit = r3_we && (r3_addr != C_ZERO);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_dbg <= '0;
    end else begin
      if (w_wb_hit) r_regs[r3_addr] <= r3_din;
      r_dbg <= (dbg_addr == C_ZERO) ? '0 : r_regs[dbg_addr];
    end
  end

  assign dbg_dout = r_dbg;
  assign w_r1_raw = (r1_addr == C_ZERO) ? '0 : r_regs[r1_addr];
  assign w_r2_raw = (r2_addr == C_ZERO) ? '0 : r_regs[r2_addr];

  reg_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_en   (iss_valid),
    .set_addr (iss_addr),
    .clr_en   (r3_we),
    .clr_addr (r3_addr),
    .lk1_addr (r1_addr),
    .lk1_busy (w_sb_busy1),
    .lk2_addr (r2_addr),
    .lk2_busy (w_sb_busy2)
  );

`ifdef REGFILE_BYPASS_EN
  logic w_r1_fwd;
  logic w_r2_fwd;
  logic w_iss_same;

  assign w_r1_fwd   = w_wb_hit && (r3_addr == r1_addr);
  assign w_r2_fwd   = w_wb_hit && (r3_addr == r2_addr);
  // A same-cycle re-issue of the written index keeps the current pend visible.
  assign w_iss_same = iss_valid && (iss_addr == r3_addr);

  assign r1_dout = w_r1_fwd ? r3_din : w_r1_raw;
  assign r2_dout = w_r2_fwd ? r3_din : w_r2_raw;
  assign r1_busy = (w_r1_fwd && !w_iss_same) ? 1'b0 : w_sb_busy1;
  assign r2_busy = (w_r2_fwd && !w_iss_same) ? 1'b0 : w_sb_busy2;
`else
  assign r1_dout = w_r1_raw;
  assign r2_dout = w_r2_raw;
  assign r1_busy = w_sb_busy1;
  assign r2_busy = w_sb_busy2;
`endif

endmodule : reg_file
`default_nettype wire

// File: tb/tb_reg_file.sv
`default_nettype none
// ============================================================================
// Module  : tb_reg_file
// Brief   : Directed self-checking bench for reg_file.
// Revision: 1.0
// ============================================================================
module tb_reg_file;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] r1_addr, r2_addr, r3_addr, iss_addr, dbg_addr;
  logic [DW-1:0] r1_dout, r2_dout, r3_din, dbg_dout;
  logic          r1_busy, r2_busy, r3_we, iss_valid;

  int checks = 0;
  int errors = 0;

  reg_file #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .r1_addr   (r1_addr),
    .r1_dout   (r1_dout),
    .r1_busy   (r1_busy),
    .r2_addr   (r2_addr),
    .r2_dout   (r2_dout),
    .r2_busy   (r2_busy),
    .r3_addr   (r3_addr),
    .r3_din    (r3_din),
    .r3_we     (r3_we),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .dbg_addr  (dbg_addr),
    .dbg_dout  (dbg_dout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    r3_we     = 1'b0;
    iss_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    r1_addr = '0; r2_addr = '0; r3_addr = '0; iss_addr = '0; dbg_addr = '0;
    r3_din = '0; r3_we = 1'b0; iss_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    r1_addr = 5'd5;
    #1;
    check("reset_dout", r1_dout, 32'h0);
    check("reset_busy", {31'b0, r1_busy}, 32'h0);
    check("reset_dbg", dbg_dout, 32'h0);

    // Load r5, mark it pending, and point debug at it
    r3_we = 1'b1; r3_addr = 5'd5; r3_din = 32'h0000_1234;
    tick();
    idle();
    iss_valid = 1'b1; iss_addr = 5'd5; dbg_addr = 5'd5;
    tick();
    idle();
    check("pre_rst_dout", r1_dout, 32'h0000_1234);
    check("pre_rst_busy", {31'b0, r1_busy}, 32'h1);
    check("pre_rst_dbg", dbg_dout, 32'h0000_1234);

    // Asynchronous reset mid-cycle
    #2 rst = 1'b1;
    #1;
    check("async_rst_dout", r1_dout, 32'h0);
    check("async_rst_busy", {31'b0, r1_busy}, 32'h0);
    check("async_rst_dbg", dbg_dout, 32'h0);
    // A write presented while reset is held is discarded
    r3_we = 1'b1; r3_addr = 5'd5; r3_din = 32'h0000_ABCD;
    tick();
    rst = 1'b0;
    idle();
    #1;
    check("rst_discard_write", r1_dout, 32'h0);

    // Write/read r7
    r2_addr = 5'd7;
    r3_we = 1'b1; r3_addr = 5'd7; r3_din = 32'hDEAD_BEEF;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("wr7_same_cycle", r2_dout, 32'hDEAD_BEEF);
`else
    check("wr7_same_cycle", r2_dout, 32'h0);
`endif
    tick();
    idle();
    check("wr7_read", r2_dout, 32'hDEAD_BEEF);

    // Register 0 ignores writes and issues
    r1_addr = 5'd0;
    r3_we = 1'b1; r3_addr = 5'd0; r3_din = 32'hFFFF_FFFF;
    iss_valid = 1'b1; iss_addr = 5'd0;
    tick();
    idle();
    check("r0_dout", r1_dout, 32'h0);
    check("r0_busy", {31'b0, r1_busy}, 32'h0);

    // Scoreboard: issue r9, then WB clears it
    iss_valid = 1'b1; iss_addr = 5'd9;
    tick();
    idle();
    r1_addr = 5'd9;
    #1;
    check("r9_busy_set", {31'b0, r1_busy}, 32'h1);
    check("r9_dout_old", r1_dout, 32'h0);
    r3_we = 1'b1; r3_addr = 5'd9; r3_din = 32'h0000_0055;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("r9_wb_busy", {31'b0, r1_busy}, 32'h0);
    check("r9_wb_dout", r1_dout, 32'h0000_0055);
`else
    check("r9_wb_busy", {31'b0, r1_busy}, 32'h1);
    check("r9_wb_dout", r1_dout, 32'h0);
`endif
    tick();
    idle();
    check("r9_after_busy", {31'b0, r1_busy}, 32'h0);
    check("r9_after_dout", r1_dout, 32'h0000_0055);

    // Set/clear collision on r12: set wins
    r2_addr = 5'd12;
    iss_valid = 1'b1; iss_addr = 5'd12;
    r3_we = 1'b1; r3_addr = 5'd12; r3_din = 32'h0000_0077;
    #1;
    check("r12_collide_busy_now", {31'b0, r2_busy}, 32'h0);
    tick();
    idle();
    check("r12_collide_busy", {31'b0, r2_busy}, 32'h1);
    check("r12_collide_dout", r2_dout, 32'h0000_0077);
    r3_we = 1'b1; r3_addr = 5'd12; r3_din = 32'h0000_0078;
    tick();
    idle();
    check("r12_cleared", {31'b0, r2_busy}, 32'h0);
    check("r12_new_dout", r2_dout, 32'h0000_0078);

    // Top index of the range
    r1_addr = 5'd31;
    r3_we = 1'b1; r3_addr = 5'd31; r3_din = 32'h3131_3131;
    tick();
    idle();
    check("r31_read", r1_dout, 32'h3131_3131);

    // Debug port sees the pre-write value, then the new one
    dbg_addr = 5'd7;
    tick();
    check("dbg_r7_prev", dbg_dout, 32'hDEAD_BEEF);
    r3_we = 1'b1; r3_addr = 5'd7; r3_din = 32'h0000_00A5;
    tick();
    idle();
    check("dbg_r7_write_cycle", dbg_dout, 32'hDEAD_BEEF);
    tick();
    check("dbg_r7_new", dbg_dout, 32'h0000_00A5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_reg_file
`default_nettype wire
